// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame sequencer in front of the FFT core; optional FFT_CTRL_HALF_EN (drain lower half only)
module fft_frame_ctrl #(
    parameter int SIZE = 16,
    parameter int IN_W = 12,
    parameter int RN   = 16,
    parameter int SKIP = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            cont,
    input  logic [IN_W-1:0]                 s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [SIZE-1:0][1:0][RN-1:0]    fft_in,
    input  logic                            fft_done,
    input  logic [SIZE-1:0][1:0][RN-1:0]    fft_out,
    output logic [RN-1:0]                   m_re,
    output logic [RN-1:0]                   m_im,
    output logic [$clog2(SIZE)-1:0]         m_idx,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            m_last,
    output logic                            busy,
    output logic                            overrun
);

    localparam int IW = $clog2(SIZE);
`ifdef FFT_CTRL_HALF_EN
    // Real input: upper half of the spectrum is the conjugate mirror of the lower half.
    localparam int NBINS = SIZE / 2;
`else
    localparam int NBINS = SIZE;
`endif
    localparam int BW  = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam int SCW = $clog2(SKIP) + 1;

    localparam logic [IW-1:0]  WR_LAST   = IW'(SIZE - 1);
    localparam logic [IW-1:0]  RD_LAST   = IW'(NBINS - 1);
    localparam logic [SCW-1:0] SKIP_LAST = SCW'(SKIP - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]     state;
    logic [IW-1:0]  wr_idx;
    logic [IW-1:0]  rd_idx;
    logic [SCW-1:0] skip_cnt;
    logic [RN-1:0]  res_re [NBINS];
    logic [RN-1:0]  res_im [NBINS];

    logic wr_fire;
    logic take;
    logic [RN-1:0] s_ext;

    assign wr_fire = (state == ST_FILL) && s_valid;
    // The first done seen in WAIT may belong to a computation that began before
    // the frame was complete, so only the SKIP-th one is trusted.
    assign take    = (state == ST_WAIT) && fft_done && (skip_cnt == SKIP_LAST);
    assign s_ext   = {{(RN - IN_W + 1){s_data[IN_W-1]}}, s_data[IN_W-2:0]};

    // Sequencer: frame fill, settle on the core, then drain bins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wr_idx   <= '0;
            rd_idx   <= '0;
            skip_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_FILL;
                        wr_idx <= '0;
                    end
                end
                ST_FILL: begin
                    if (s_valid) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (wr_idx == WR_LAST) begin
                            state    <= ST_WAIT;
                            skip_cnt <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (fft_done) begin
                        skip_cnt <= skip_cnt + 1'b1;
                        if (skip_cnt == SKIP_LAST) begin
                            state  <= ST_DRAIN;
                            rd_idx <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_ready) begin
                        if (rd_idx == RD_LAST) begin
                            rd_idx <= '0;
                            wr_idx <= '0;
                            state  <= cont ? ST_FILL : ST_IDLE;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Core input frame: written only while filling, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            fft_in <= '0;
        end else if (wr_fire) begin
            fft_in[wr_idx][0] <= s_ext;
            fft_in[wr_idx][1] <= '0;
        end
    end

    // Result buffer: snapshot of the core output on the qualifying done.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NBINS; k++) begin
                res_re[k] <= '0;
                res_im[k] <= '0;
            end
        end else if (take) begin
            for (int k = 0; k < NBINS; k++) begin
                res_re[k] <= fft_out[k][0];
                res_im[k] <= fft_out[k][1];
            end
        end
    end

    // Sticky overrun: any sample offered while the controller cannot take it.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            overrun <= 1'b0;
        end else if (s_valid && ((state == ST_WAIT) || (state == ST_DRAIN) ||
                                 ((state == ST_IDLE) && cont))) begin
            overrun <= 1'b1;
        end
    end

    assign s_ready = (state == ST_FILL);
    assign m_valid = (state == ST_DRAIN);
    assign m_last  = (state == ST_DRAIN) && (rd_idx == RD_LAST);
    assign busy    = (state != ST_IDLE);
    assign m_idx   = rd_idx;
    assign m_re    = res_re[rd_idx[BW-1:0]];
    assign m_im    = res_im[rd_idx[BW-1:0]];

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer in front of the recursive radix-2 FFT core. It collects a stream of signed ADC samples into a SIZE-point frame and holds that frame stable on the core's parallel input. It waits until the free-running core has produced a result computed entirely from the held frame, latches that result, then streams the bins out over a valid/ready interface. It sits between the ADC sample pipeline and the spectrum/display consumers.

## Interface
- SIZE, 16: FFT points; power of two, 2..128; must match the attached core.
- IN_W, 12: sample width, signed two's complement.
- RN, 16: core word width; RN >= IN_W.
- SKIP, 2: number of fft_done pulses counted after the frame is complete; result taken on the SKIP-th.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  arm capture; clears overrun.
- cont  in  1  continuous mode: refill immediately after drain.
- s_data  in  IN_W  sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  high only in FILL.
- fft_in  out  [SIZE][2] x RN  core input; [k][0] = sign-extended sample k, [k][1] = 0.
- fft_done  in  1  core done pulse.
- fft_out  in  [SIZE][2] x RN  core result.
- m_re, m_im  out  RN  bin value.
- m_idx  out  clog2(SIZE)  bin index.
- m_valid  out  1  bin valid.
- m_ready  in  1  consumer ready.
- m_last  out  1  final bin of frame.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky; a sample was dropped.

## Operation
- States: IDLE, FILL, WAIT, DRAIN.
- IDLE: start=1 -> FILL, with wr_idx=0 and overrun cleared. All other inputs are ignored.
- FILL: each s_valid&s_ready writes fft_in[wr_idx], sign-extended to RN with imag 0, then wr_idx++. The write at wr_idx=SIZE-1 -> WAIT, with skip_cnt=0.
- fft_in changes only in FILL. It is otherwise held, so it is stable across SKIP full core computations.
- WAIT: each fft_done increments skip_cnt. When fft_done=1 and skip_cnt=SKIP-1:
  - latch all of fft_out into the result buffer;
  - -> DRAIN with rd_idx=0.
- The first done after WAIT entry can come from a computation that straddled the load. For that reason SKIP must be >= 2.
- DRAIN: m_valid=1. m_re/m_im/m_idx come from result buffer[rd_idx]. Each m_valid&m_ready increments rd_idx.
- On the transfer of the last bin: cont=1 -> FILL with wr_idx=0; cont=0 -> IDLE.
- m_last=1 when rd_idx = last bin index.
- overrun: set when s_valid=1 in WAIT or DRAIN, or in IDLE while cont=1. Cleared only by start in IDLE, or by reset.
- No arithmetic on bins. Values pass through bit-exact from fft_out.

## Timing
- Reset values:
  - state IDLE; s_ready, m_valid, m_last, busy, overrun all 0;
  - fft_in all 0; m_re, m_im, m_idx 0; counters 0.
- start sampled in IDLE: s_ready=1 on the next cycle.
- One sample accepted per cycle max. A frame needs SIZE accepting cycles.
- Last sample accepted at cycle t: state=WAIT at t+1, s_ready=0.
- Qualifying fft_done at cycle t: m_valid=1 with bin 0 at t+1.
- m_valid, once high, is not dropped until the handshake completes. Data is stable while m_valid&!m_ready.
- Last transfer at t: m_valid=0 at t+1. In cont mode, s_ready=1 at t+1.
- fft_done in IDLE, FILL or DRAIN is ignored. It does not advance skip_cnt.
- reset asserted in any state returns to reset values on the next edge. A partial frame is discarded; no m_valid follows.
- start asserted simultaneously with reset: reset wins.

## Configuration
- FFT_CTRL_HALF_EN defined: DRAIN outputs only bins 0..SIZE/2-1, since input is real and the upper half is conjugate-symmetric. m_last is at SIZE/2-1, and the result buffer stores only SIZE/2 entries.
- Undefined: all SIZE bins are drained; m_last is at SIZE-1.

## Test plan
- Directed reset: mid-FILL (after 5 of 16 samples), reset, then start. Required:
  - wr_idx restarts at 0;
  - first bin output only after 16 new samples and 2 done pulses;
  - all outputs at reset values on the cycle after reset.
- DC, SIZE=8, with the real core: samples all 100, m_ready=1. Required:
  - bin0 re=800 (±1), im 0 (±1);
  - bins 1..7 within ±1 of 0;
  - m_last only on idx 7.
- Impulse with a stub core (done every 6 cycles, fft_out = echo of fft_in): samples 1000,0,0,... Required:
  - bin0 = 1000;
  - the result is taken on the 2nd done after the last sample;
  - the done pulse during FILL is ignored.
- Backpressure: m_ready toggled 1-in-3. Required: m_re, m_im and m_idx stay stable while stalled; all 16 bins delivered in order, none dropped or repeated.
- Overrun: cont=1, s_valid held 1 throughout. Required:
  - overrun=1 after the first WAIT cycle, staying set across frames;
  - start in IDLE (with cont=0) clears it.
- FFT_CTRL_HALF_EN, SIZE=16: required 8 bins per frame, m_last at idx 7; in cont mode the next FILL begins the cycle after.
